// File: rtl/types_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package types_pkg;

    localparam int XLEN       = 32;
    localparam int CNT_W      = $clog2(XLEN) + 1;
    localparam int MULDIV_LAT = XLEN + 1;

    // M-extension operation codes, laid out like the ALU control codes
    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Divide and remainder ops all have the top op bit set
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Applies the recorded negate flags to the unsigned iteration result and
// picks the slice the op asks for (product low/high, quotient, remainder).
module muldiv_sign_fix
    import types_pkg::*;
(
    input  logic [2*XLEN-1:0] i_raw,
    input  logic [2:0]        i_op,
    input  logic              i_negProd,
    input  logic              i_negRem,
    output logic [XLEN-1:0]   o_result
);

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // Negate product/quotient on differing signs, remainder follows the dividend
    always_comb begin
        w_prod = i_negProd ? -i_raw : i_raw;
        w_quo  = i_negProd ? -i_raw[XLEN-1:0] : i_raw[XLEN-1:0];
        w_rem  = i_negRem ? -i_raw[2*XLEN-1:XLEN] : i_raw[2*XLEN-1:XLEN];
        case (i_op)
            MULDIV_MUL:                               o_result = w_prod[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                  o_result = w_quo;
            default:                                  o_result = w_rem;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, start/busy/done handshake, flushable.
module muldiv_unit
    import types_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     r_state;
    muldiv_state_e     w_nextState;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_operand;
    logic              r_negProd;
    logic              r_negRem;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_aNeg;
    logic              w_bNeg;
    logic [XLEN-1:0]   w_aMag;
    logic [XLEN-1:0]   w_bMag;
    logic              w_divZero;
    logic              w_overflow;
    logic              w_special;
    logic [XLEN-1:0]   w_specialResult;
    logic [XLEN:0]     w_mulSum;
    logic [XLEN+1:0]   w_divTrial;
    logic [2*XLEN-1:0] w_accStep;
    logic              w_lastIter;
    logic [XLEN-1:0]   w_fixResult;

    // Accept decode, operand magnitudes and the two no-iteration cases
    always_comb begin
        w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start && !flush;
        w_aNeg     = a[XLEN-1] && ((op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
                                   (op == MULDIV_DIV)  || (op == MULDIV_REM));
        w_bNeg     = b[XLEN-1] && ((op == MULDIV_MULH) || (op == MULDIV_DIV) ||
                                   (op == MULDIV_REM));
        w_aMag     = w_aNeg ? -a : a;
        w_bMag     = w_bNeg ? -b : b;
        w_divZero  = is_div_op(op) && (b == '0);
        w_overflow = ((op == MULDIV_DIV) || (op == MULDIV_REM)) &&
                     (a == MOST_NEG) && (b == '1);
        w_special  = w_divZero || w_overflow;
        w_specialResult = '0;
        if (w_divZero) begin
            w_specialResult = op[1] ? a : '1;
        end else if (w_overflow) begin
            w_specialResult = op[1] ? '0 : a;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_mulSum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_operand};
        w_divTrial = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_operand};
        w_accStep  = r_acc;
        if (!is_div_op(r_op)) begin
            if (r_acc[0]) begin
                w_accStep = {w_mulSum, r_acc[XLEN-1:1]};
            end else begin
                w_accStep = {1'b0, r_acc[2*XLEN-1:1]};
            end
        end else begin
            if (!w_divTrial[XLEN+1]) begin
                w_accStep = {w_divTrial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_accStep = {r_acc[2*XLEN-2:0], 1'b0};
            end
        end
        w_lastIter = (r_count == CNT_W'(XLEN-1));
    end

    muldiv_sign_fix u_signFix (
        .i_raw     (w_accStep),
        .i_op      (r_op),
        .i_negProd (r_negProd),
        .i_negRem  (r_negRem),
        .o_result  (w_fixResult)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; flush overrides everything, including a new start
    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        w_nextState = w_special ? DONE : CALC;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
                CALC: begin
                    if (w_lastIter) begin
                        w_nextState = DONE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Operand latch on accept, iteration during CALC, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_op      <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_negProd <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= op;
            r_count   <= '0;
            r_negProd <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            if (is_div_op(op)) begin
                r_acc     <= {{XLEN{1'b0}}, w_aMag};
                r_operand <= w_bMag;
            end else begin
                r_acc     <= {{XLEN{1'b0}}, w_bMag};
                r_operand <= w_aMag;
            end
            if (w_special) begin
                r_result <= w_specialResult;
            end
        end else if ((r_state == CALC) && !flush) begin
            r_acc   <= w_accStep;
            r_count <= r_count + CNT_W'(1);
            if (w_lastIter) begin
                r_result <= w_fixResult;
            end
        end
    end

    assign busy   = (r_state == CALC);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the RV32M instructions; sits beside the single-cycle ALU in the execute stage.
- Takes the same operand pair (a, b) plus a 3-bit M-op code.
- Returns a result through a start/busy/done handshake.
- Control stalls the PC while busy is high, then writes result to the register file on done.

Parameters:
- XLEN, 32 (from types_pkg), operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- flush  in  1  abort the current operation (pipeline redirect).
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  final value; held until the next accepted start or reset.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset mid-operation discards it; nothing is pending after release.
- States: IDLE, CALC, DONE.
- Start accepted (IDLE or DONE, start=1, flush=0):
  - latch op, a, b; counter=0.
  - Normal case: go to CALC.
  - Special case: go directly to DONE with the special result.
- Operand conditioning at accept:
  - Signed operands (MULH/DIV/REM: a and b; MULHSU: a only) are replaced by their magnitudes; negate flags are recorded.
  - Sign of result: quotient and product negate iff the operand signs differ; remainder takes the sign of the dividend.
- CALC:
  - Exactly XLEN iterations, one per cycle.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract (quotient in the low half, partial remainder in the high half).
  - After iteration XLEN-1 (counter==XLEN-1): apply sign fix-up, register result, go to DONE.
- DONE (one cycle): done=1.
  - start=1 → accept a new operation (back-to-back).
  - Otherwise → IDLE.
- Latency from the accepting edge to done high: normal = XLEN+1 cycles (done visible XLEN+1 cycles later); special = 1 cycle.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases (no iteration):
  - Divide by zero: quotient = all ones; remainder = a.
  - Signed overflow (a = most negative, b = -1, DIV/REM): quotient = a; remainder = 0.
- start while in CALC: ignored; no queuing.
- flush=1: forces IDLE next edge from any state, clears done; result is left unchanged. If start and flush are both high, flush wins.
- busy=1 exactly in CALC. done and busy are never high together.
- Result is registered only; no combinational path from inputs to outputs.

Decomposition:
- types_pkg:
  - MULDIV op localparams (MUL..REMU, 3-bit), following the ALU control-code style.
  - muldiv_state_e enum {IDLE, CALC, DONE}.
  - MULDIV_LAT = XLEN+1.
- One natural sub-module: muldiv_sign_fix. Combinational; takes the raw 2*XLEN product or the quotient/remainder plus negate flags and op, and returns the final XLEN result. The unit itself holds the FSM, counter and iteration datapath.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (-3) → result=0xFFFFFFEB; done exactly 33 cycles after the accepting edge; busy high for 32 cycles.
- MULH, a=b=0x80000000 → 0x40000000; MULHU on the same operands → 0x40000000; MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM on the same operands → 0xFFFFFFFF; DIVU, a=100, b=7 → 14; REMU → 2.
- DIVU, a=0x1234, b=0 → 0xFFFFFFFF, done 1 cycle after accept, busy never high; REM, a=0x1234, b=0 → 0x1234; DIV, a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- Back-to-back: start held through DONE with a second MUL 3*5 → second done 33 cycles after the first done, result=15. start pulsed mid-CALC → ignored; result of the first op unchanged.
- Handshake interruptions:
  - flush at CALC cycle 10 → IDLE next edge, no done; result keeps its prior value.
  - rst_n low at CALC cycle 5 → busy/done/result go 0 immediately (asynchronously); next op after release completes normally.
